// File: rtl/risc_toy_decode_stage.sv
// RISC_TOY decode / operand-fetch stage: combinational regfile addressing, write-back bypass,
// and a valid/ready output register. Optional macro ILLEGAL_OP_TRAP_EN flags opcodes 23..31.
module risc_toy_decode_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int PCW = 30
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [31:0]    IN_INSTR,
  input  logic [PCW-1:0] IN_PC,
  input  logic           FLUSH,
  output logic [AW-1:0]  RA0,
  output logic [AW-1:0]  RA1,
  input  logic [DW-1:0]  RD0,
  input  logic [DW-1:0]  RD1,
  input  logic           WB_EN,
  input  logic [AW-1:0]  WB_ADDR,
  input  logic [DW-1:0]  WB_DATA,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [4:0]     OUT_OPCODE,
  output logic [DW-1:0]  OUT_VALA,
  output logic [DW-1:0]  OUT_VALB,
  output logic [DW-1:0]  OUT_IMM,
  output logic [AW-1:0]  OUT_DEST,
  output logic           OUT_WEN,
  output logic [PCW-1:0] OUT_PC,
  output logic           OUT_ILLEGAL
);

  localparam logic [4:0] OP_ADDI = 5'd0,  OP_ANDI = 5'd1,  OP_ORI  = 5'd2,  OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_NEG  = 5'd6,  OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12, OP_SHL  = 5'd13, OP_ROR  = 5'd14, OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16, OP_J    = 5'd17, OP_JL   = 5'd18, OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20, OP_ST   = 5'd21, OP_STR  = 5'd22;

  logic [4:0]    opcode;
  logic [AW-1:0] fld_a, fld_b, fld_c;
  logic [DW-1:0] sext17, zext17, sext22, br_imm, shamt_val;

  assign opcode    = IN_INSTR[31:27];
  assign fld_a     = AW'(IN_INSTR[26:22]);
  assign fld_b     = AW'(IN_INSTR[21:17]);
  assign fld_c     = AW'(IN_INSTR[16:12]);
  assign sext17    = {{(DW-17){IN_INSTR[16]}}, IN_INSTR[16:0]};
  assign zext17    = {{(DW-17){1'b0}}, IN_INSTR[16:0]};
  assign sext22    = {{(DW-22){IN_INSTR[21]}}, IN_INSTR[21:0]};
  assign br_imm    = {{(DW-3){1'b0}}, IN_INSTR[2:0]};
  assign shamt_val = {{(DW-5){1'b0}}, IN_INSTR[4:0]};

  logic [AW-1:0] ra0_next, ra1_next, dest_next;
  logic          a_src_next, b_src_next, wen_next;
  logic [DW-1:0] imm_next, valb_lit_next;
`ifdef ILLEGAL_OP_TRAP_EN
  logic          illegal_next;
`endif

  // a_src/b_src mark operands read from the register file; they become the held tags
  always_comb begin
    ra0_next      = '0;
    ra1_next      = '0;
    dest_next     = '0;
    a_src_next    = 1'b0;
    b_src_next    = 1'b0;
    wen_next      = 1'b0;
    imm_next      = '0;
    valb_lit_next = '0;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_next  = 1'b0;
`endif
    case (opcode)
      OP_ADDI, OP_LD, OP_ST: begin
        ra0_next   = fld_b;
        ra1_next   = fld_a;
        a_src_next = 1'b1;
        b_src_next = 1'b1;
        imm_next   = sext17;
        wen_next   = (opcode != OP_ST);
      end
      OP_ANDI, OP_ORI, OP_MOVI: begin
        ra0_next   = fld_b;
        ra1_next   = fld_a;
        a_src_next = 1'b1;
        b_src_next = 1'b1;
        imm_next   = zext17;
        wen_next   = 1'b1;
      end
      OP_ADD, OP_SUB, OP_NEG, OP_NOT, OP_AND, OP_OR, OP_XOR: begin
        ra0_next   = fld_b;
        ra1_next   = fld_c;
        a_src_next = 1'b1;
        b_src_next = 1'b1;
        wen_next   = 1'b1;
      end
      OP_LSR, OP_ASR, OP_SHL, OP_ROR: begin
        ra0_next   = fld_b;
        a_src_next = 1'b1;
        wen_next   = 1'b1;
        if (IN_INSTR[5]) begin
          ra1_next   = fld_c;
          b_src_next = 1'b1;
        end else begin
          valb_lit_next = shamt_val;
        end
      end
      OP_BR, OP_BRL: begin
        ra0_next   = fld_b;
        ra1_next   = fld_c;
        a_src_next = 1'b1;
        b_src_next = 1'b1;
        imm_next   = br_imm;
        wen_next   = (opcode == OP_BRL);
      end
      OP_J, OP_JL, OP_LDR, OP_STR: begin
        ra1_next   = fld_a;
        b_src_next = 1'b1;
        imm_next   = sext22;
        wen_next   = (opcode == OP_JL) || (opcode == OP_LDR);
      end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_next = 1'b1;
`endif
      end
    endcase
    if (wen_next) dest_next = fld_a;
  end

  logic [DW-1:0] byp_a, byp_b, vala_next, valb_next;

  always_comb begin
    byp_a     = (WB_EN && (WB_ADDR == ra0_next)) ? WB_DATA : RD0;
    byp_b     = (WB_EN && (WB_ADDR == ra1_next)) ? WB_DATA : RD1;
    vala_next = a_src_next ? byp_a : '0;
    valb_next = b_src_next ? byp_b : valb_lit_next;
  end

  logic           valid_reg, wen_reg, a_src_reg, b_src_reg;
  logic [4:0]     opcode_reg;
  logic [DW-1:0]  vala_reg, valb_reg, imm_reg;
  logic [AW-1:0]  dest_reg, a_tag_reg, b_tag_reg;
  logic [PCW-1:0] pc_reg;
  logic           capture;

  assign RA0      = ra0_next;
  assign RA1      = ra1_next;
  assign IN_READY = !valid_reg || OUT_READY;
  assign capture  = IN_VALID && IN_READY && !FLUSH;

  // Priority: flush, then capture, then drain; otherwise a stalled bundle only refreshes operands
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_reg  <= 1'b0;
      opcode_reg <= '0;
      vala_reg   <= '0;
      valb_reg   <= '0;
      imm_reg    <= '0;
      dest_reg   <= '0;
      wen_reg    <= 1'b0;
      pc_reg     <= '0;
      a_tag_reg  <= '0;
      b_tag_reg  <= '0;
      a_src_reg  <= 1'b0;
      b_src_reg  <= 1'b0;
    end else if (FLUSH) begin
      valid_reg <= 1'b0;
    end else if (capture) begin
      valid_reg  <= 1'b1;
      opcode_reg <= opcode;
      vala_reg   <= vala_next;
      valb_reg   <= valb_next;
      imm_reg    <= imm_next;
      dest_reg   <= dest_next;
      wen_reg    <= wen_next;
      pc_reg     <= IN_PC;
      a_tag_reg  <= ra0_next;
      b_tag_reg  <= ra1_next;
      a_src_reg  <= a_src_next;
      b_src_reg  <= b_src_next;
    end else if (OUT_READY) begin
      valid_reg <= 1'b0;
    end else if (valid_reg) begin
      if (WB_EN && a_src_reg && (WB_ADDR == a_tag_reg)) vala_reg <= WB_DATA;
      if (WB_EN && b_src_reg && (WB_ADDR == b_tag_reg)) valb_reg <= WB_DATA;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)            illegal_reg <= 1'b0;
    else if (FLUSH)       illegal_reg <= illegal_reg;
    else if (capture)     illegal_reg <= illegal_next;
  end

  assign OUT_ILLEGAL = illegal_reg;
`else
  assign OUT_ILLEGAL = 1'b0;
`endif

  assign OUT_VALID  = valid_reg;
  assign OUT_OPCODE = opcode_reg;
  assign OUT_VALA   = vala_reg;
  assign OUT_VALB   = valb_reg;
  assign OUT_IMM    = imm_reg;
  assign OUT_DEST   = dest_reg;
  assign OUT_WEN    = wen_reg;
  assign OUT_PC     = pc_reg;

endmodule

// File: tb/tb_risc_toy_decode_stage.sv
// Self-checking bench for risc_toy_decode_stage: directed scenarios plus a randomized stream
// checked against a behavioural decode/handshake model.
module tb_risc_toy_decode_stage;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int PCW = 30;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]     opcode;
    logic [DW-1:0]  vala;
    logic [DW-1:0]  valb;
    logic [DW-1:0]  imm;
    logic [AW-1:0]  dest;
    logic           wen;
    logic [PCW-1:0] pc;
    logic           illegal;
  } bundle_t;

  typedef struct packed {
    bundle_t       b;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          a_src;
    logic          b_src;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RSTN;
  logic           IN_VALID, IN_READY, FLUSH, WB_EN, OUT_VALID, OUT_READY, OUT_WEN, OUT_ILLEGAL;
  logic [31:0]    IN_INSTR;
  logic [PCW-1:0] IN_PC, OUT_PC;
  logic [AW-1:0]  RA0, RA1, WB_ADDR, OUT_DEST;
  logic [DW-1:0]  RD0, RD1, WB_DATA, OUT_VALA, OUT_VALB, OUT_IMM;
  logic [4:0]     OUT_OPCODE;
  bundle_t        act;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  risc_toy_decode_stage #(.DW(DW), .AW(AW), .PCW(PCW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR), .IN_PC(IN_PC),
    .FLUSH(FLUSH), .RA0(RA0), .RA1(RA1), .RD0(RD0), .RD1(RD1),
    .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OPCODE(OUT_OPCODE),
    .OUT_VALA(OUT_VALA), .OUT_VALB(OUT_VALB), .OUT_IMM(OUT_IMM), .OUT_DEST(OUT_DEST),
    .OUT_WEN(OUT_WEN), .OUT_PC(OUT_PC), .OUT_ILLEGAL(OUT_ILLEGAL)
  );

  assign act = {OUT_OPCODE, OUT_VALA, OUT_VALB, OUT_IMM, OUT_DEST, OUT_WEN, OUT_PC, OUT_ILLEGAL};

  // Reference decode from the instruction-class rules; operands not sourced from a register or
  // literal read as 0, DEST reads as 0 when nothing is written.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [PCW-1:0] pc,
                                      input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                                      input logic wbe, input logic [AW-1:0] wba,
                                      input logic [DW-1:0] wbd);
    exp_t e;
    int unsigned op;
    logic [AW-1:0] ra, rb, rc;
    op = {27'd0, ins[31:27]};
    ra = ins[26:22];
    rb = ins[21:17];
    rc = ins[16:12];
    e = '0;
    e.b.opcode = ins[31:27];
    e.b.pc = pc;
    if (op inside {0, 1, 2, 3, 19, 21}) begin
      e.ra0 = rb; e.ra1 = ra; e.a_src = 1'b1; e.b_src = 1'b1;
      e.b.imm = (op inside {1, 2, 3}) ? {15'd0, ins[16:0]} : {{15{ins[16]}}, ins[16:0]};
      e.b.wen = (op != 21);
    end else if (op inside {[4:10]}) begin
      e.ra0 = rb; e.ra1 = rc; e.a_src = 1'b1; e.b_src = 1'b1; e.b.wen = 1'b1;
    end else if (op inside {[11:14]}) begin
      e.ra0 = rb; e.a_src = 1'b1; e.b.wen = 1'b1;
      if (ins[5]) begin
        e.ra1 = rc; e.b_src = 1'b1;
      end else begin
        e.b.valb = {27'd0, ins[4:0]};
      end
    end else if (op inside {15, 16}) begin
      e.ra0 = rb; e.ra1 = rc; e.a_src = 1'b1; e.b_src = 1'b1;
      e.b.imm = {29'd0, ins[2:0]};
      e.b.wen = (op == 16);
    end else if (op inside {17, 18, 20, 22}) begin
      e.ra1 = ra; e.b_src = 1'b1;
      e.b.imm = {{10{ins[21]}}, ins[21:0]};
      e.b.wen = (op inside {18, 20});
    end else begin
      e.b.illegal = TRAP;
    end
    if (e.a_src) e.b.vala = (wbe && wba == e.ra0) ? wbd : rd0;
    if (e.b_src) e.b.valb = (wbe && wba == e.ra1) ? wbd : rd1;
    if (e.b.wen) e.b.dest = ra;
    return e;
  endfunction

  task automatic idle();
    IN_VALID = 1'b0; IN_INSTR = '0; IN_PC = '0; FLUSH = 1'b0;
    RD0 = '0; RD1 = '0; WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0; OUT_READY = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    RSTN = 1'b1;
    #2 RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", OUT_VALID); end
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", IN_READY); end
    total++; if (act !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", act); end
    RSTN = 1'b1;
    @(negedge CLK);
    $display("txn reset released");
  endtask

  task automatic test_addi();
    idle();
    IN_VALID = 1'b1; IN_INSTR = {5'd0, 5'd3, 5'd1, 17'h1FFFB}; IN_PC = 30'h100; RD0 = 32'd10;
    #1;
    total++; if ({RA0, RA1} !== {5'd1, 5'd3}) begin bad++; $display("FAIL addi_ra got=%0d,%0d want=1,3", RA0, RA1); end
    @(negedge CLK);
    IN_VALID = 1'b0;
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b want=1", OUT_VALID); end
    total++; if (OUT_VALA !== 32'd10) begin bad++; $display("FAIL addi_vala got=%h want=a", OUT_VALA); end
    total++; if (OUT_IMM !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_imm got=%h want=fffffffb", OUT_IMM); end
    total++; if ({OUT_DEST, OUT_WEN} !== {5'd3, 1'b1}) begin bad++; $display("FAIL addi_dest got=%0d/%b want=3/1", OUT_DEST, OUT_WEN); end
    total++; if (OUT_PC !== 30'h100) begin bad++; $display("FAIL addi_pc got=%h want=100", OUT_PC); end
    $display("txn addi pc=%h vala=%h imm=%h", OUT_PC, OUT_VALA, OUT_IMM);
    @(negedge CLK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", OUT_VALID); end
  endtask

  task automatic test_imm_shift();
    logic [31:0] ins [3];
    logic [DW-1:0] want [3];
    ins[0] = {5'd2, 5'd4, 5'd2, 17'h10000};
    ins[1] = {5'd11, 5'd2, 5'd1, 5'd9, 6'd0, 1'b0, 5'd7};
    ins[2] = {5'd11, 5'd2, 5'd1, 5'd9, 6'd0, 1'b1, 5'd7};
    want[0] = 32'h00010000; want[1] = 32'd7; want[2] = 32'd3;
    for (int i = 0; i < 3; i++) begin
      idle();
      IN_VALID = 1'b1; IN_INSTR = ins[i]; RD0 = 32'h1234; RD1 = 32'd3;
      @(negedge CLK);
      IN_VALID = 1'b0;
      if (i == 0) begin
        total++; if (OUT_IMM !== want[i]) begin bad++; $display("FAIL ori_imm got=%h want=%h", OUT_IMM, want[i]); end
      end else begin
        total++; if (OUT_VALB !== want[i]) begin bad++; $display("FAIL shift%0d_valb got=%h want=%h", i, OUT_VALB, want[i]); end
      end
      total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL imm_shift%0d_valid got=%b want=1", i, OUT_VALID); end
      $display("txn op=%0d valb=%h imm=%h", OUT_OPCODE, OUT_VALB, OUT_IMM);
    end
    @(negedge CLK);
  endtask

  task automatic test_bypass();
    idle();
    IN_VALID = 1'b1; IN_INSTR = {5'd4, 5'd2, 5'd4, 5'd5, 12'd0}; RD0 = 32'd1; RD1 = 32'd7;
    WB_EN = 1'b1; WB_ADDR = 5'd4; WB_DATA = 32'd99;
    @(negedge CLK);
    idle();
    total++; if (OUT_VALA !== 32'd99) begin bad++; $display("FAIL bypass_vala got=%0d want=99", OUT_VALA); end
    total++; if (OUT_VALB !== 32'd7) begin bad++; $display("FAIL bypass_valb got=%0d want=7", OUT_VALB); end
    $display("txn add bypass vala=%0d valb=%0d", OUT_VALA, OUT_VALB);
    @(negedge CLK);
  endtask

  task automatic test_stall();
    idle();
    IN_VALID = 1'b1; IN_INSTR = {5'd4, 5'd1, 5'd6, 5'd7, 12'd0}; IN_PC = 30'h20;
    RD0 = 32'h11; RD1 = 32'h22; OUT_READY = 1'b0;
    @(negedge CLK);
    IN_INSTR = {5'd5, 5'd2, 5'd3, 5'd4, 12'd0}; IN_PC = 30'h21;
    for (int i = 0; i < 3; i++) begin
      RD0 = $urandom; RD1 = $urandom;
      #1;
      total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL stall_in_ready c%0d got=%b want=0", i, IN_READY); end
      @(negedge CLK);
      total++; if ({OUT_VALID, OUT_VALA, OUT_VALB, OUT_PC} !== {1'b1, 32'h11, 32'h22, 30'h20}) begin
        bad++; $display("FAIL stall_hold c%0d got=%b/%h/%h/%h want=1/11/22/20", i, OUT_VALID, OUT_VALA, OUT_VALB, OUT_PC);
      end
    end
    WB_EN = 1'b1; WB_ADDR = 5'd6; WB_DATA = 32'h55;
    @(negedge CLK);
    WB_EN = 1'b0;
    total++; if ({OUT_VALA, OUT_VALB} !== {32'h55, 32'h22}) begin
      bad++; $display("FAIL stall_refresh got=%h/%h want=55/22", OUT_VALA, OUT_VALB);
    end
    $display("txn stalled bundle refreshed vala=%h", OUT_VALA);
    OUT_READY = 1'b1; RD0 = 32'd5; RD1 = 32'd6;
    #1;
    total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", IN_READY); end
    @(negedge CLK);
    IN_VALID = 1'b0;
    total++; if ({OUT_VALID, OUT_OPCODE, OUT_VALA, OUT_PC} !== {1'b1, 5'd5, 32'd5, 30'h21}) begin
      bad++; $display("FAIL release_capture got=%b/%0d/%h/%h want=1/5/5/21", OUT_VALID, OUT_OPCODE, OUT_VALA, OUT_PC);
    end
    $display("txn released pc=%h", OUT_PC);
    @(negedge CLK);
  endtask

  task automatic test_flush();
    idle();
    IN_VALID = 1'b1; IN_INSTR = {5'd9, 5'd1, 5'd2, 5'd3, 12'd0};
    @(negedge CLK);
    FLUSH = 1'b1; IN_INSTR = {5'd10, 5'd1, 5'd2, 5'd3, 12'd0};
    @(negedge CLK);
    FLUSH = 1'b0; IN_VALID = 1'b0;
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", OUT_VALID); end
    @(negedge CLK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", OUT_VALID); end
    $display("txn flush done");
    IN_VALID = 1'b1; OUT_READY = 1'b0; RD0 = 32'hABCD;
    @(negedge CLK);
    IN_VALID = 1'b0;
    RSTN = 1'b0;
    #1;
    total++; if ({OUT_VALID, OUT_VALA} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL reset_mid_stall got=%b/%h want=0/0", OUT_VALID, OUT_VALA);
    end
    @(negedge CLK);
    RSTN = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b want=0", OUT_VALID); end
    $display("txn reset mid-stall done");
  endtask

  task automatic test_illegal();
    logic [26:0] rest;
    rest = 27'($urandom);
    idle();
    IN_VALID = 1'b1; IN_INSTR = {5'd25, rest}; RD0 = 32'hDEAD; RD1 = 32'hBEEF;
    @(negedge CLK);
    IN_VALID = 1'b0;
    total++; if ({OUT_VALID, OUT_OPCODE} !== {1'b1, 5'd25}) begin
      bad++; $display("FAIL illegal_capture got=%b/%0d want=1/25", OUT_VALID, OUT_OPCODE);
    end
    total++; if ({OUT_ILLEGAL, OUT_WEN} !== {TRAP, 1'b0}) begin
      bad++; $display("FAIL illegal_flags got=%b/%b want=%b/0", OUT_ILLEGAL, OUT_WEN, TRAP);
    end
    total++; if ({OUT_VALA, OUT_VALB} !== 64'd0) begin
      bad++; $display("FAIL illegal_operands got=%h/%h want=0/0", OUT_VALA, OUT_VALB);
    end
    $display("txn opcode25 illegal=%b", OUT_ILLEGAL);
    @(negedge CLK);
  endtask

  task automatic test_random();
    bit mv;
    bundle_t mb;
    logic [AW-1:0] mta, mtb;
    bit msa, msb;
    exp_t e;
    logic [31:0] ins;
    idle();
    @(negedge CLK);
    mv = 1'b0; mb = '0; mta = '0; mtb = '0; msa = 1'b0; msb = 1'b0;
    for (int c = 0; c < 600; c++) begin
      total++; if (OUT_VALID !== mv) begin bad++; $display("FAIL rnd_valid c%0d got=%b want=%b", c, OUT_VALID, mv); end
      if (mv) begin
        total++; if (act !== mb) begin bad++; $display("FAIL rnd_bundle c%0d got=%h want=%h", c, act, mb); end
      end
      ins = $urandom;
      ins[26:22] = 5'($urandom_range(0, 3));
      ins[21:17] = 5'($urandom_range(0, 3));
      ins[16:12] = 5'($urandom_range(0, 3));
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_INSTR  = ins;
      IN_PC     = 30'($urandom);
      FLUSH     = ($urandom_range(0, 15) == 0);
      RD0       = $urandom;
      RD1       = $urandom;
      WB_EN     = $urandom_range(0, 1) != 0;
      WB_ADDR   = 5'($urandom_range(0, 3));
      WB_DATA   = $urandom;
      OUT_READY = ($urandom_range(0, 2) != 0);
      #1;
      e = ref_decode(IN_INSTR, IN_PC, RD0, RD1, WB_EN, WB_ADDR, WB_DATA);
      total++; if (IN_READY !== (!mv || OUT_READY)) begin
        bad++; $display("FAIL rnd_in_ready c%0d got=%b want=%b", c, IN_READY, (!mv || OUT_READY));
      end
      total++; if ({RA0, RA1} !== {e.ra0, e.ra1}) begin
        bad++; $display("FAIL rnd_ra c%0d got=%0d,%0d want=%0d,%0d", c, RA0, RA1, e.ra0, e.ra1);
      end
      if (mv && OUT_READY && !FLUSH) $display("txn consumed pc=%h op=%0d", mb.pc, mb.opcode);
      if (FLUSH) begin
        mv = 1'b0;
      end else if (IN_VALID && (!mv || OUT_READY)) begin
        mv = 1'b1; mb = e.b; mta = e.ra0; mtb = e.ra1; msa = e.a_src; msb = e.b_src;
      end else if (OUT_READY) begin
        mv = 1'b0;
      end else if (mv) begin
        if (WB_EN && msa && WB_ADDR == mta) mb.vala = WB_DATA;
        if (WB_EN && msb && WB_ADDR == mtb) mb.valb = WB_DATA;
      end
      @(negedge CLK);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm_shift();
    test_bypass();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_toy_decode_stage.md
Name:
risc_toy_decode_stage

Overview:
- Parametrised decode / operand-fetch pipeline stage for the RISC_TOY core. Sits between fetch and execute.
- Decodes the 5-bit opcode and drives register-file read addresses combinationally from the incoming instruction.
- Selects operands and extends immediates; forwards write-back data into operands.
- Holds results in a valid/ready pipeline register with stall, flush and stall-time operand refresh.

Parameters:
DW, 32, datapath / register width (>=22)
AW, 5, register-file address width (instruction fields are 5 bits; upper AW-5 bits zero-filled)
PCW, 30, word-address width of the PC carried with the instruction

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
IN_VALID  in  1  fetch presents an instruction
IN_READY  out  1  stage accepts instruction this cycle
IN_INSTR  in  32  instruction word
IN_PC  in  PCW  word address of IN_INSTR
FLUSH  in  1  discard held and incoming instruction
RA0  out  AW  regfile read address 0 (combinational from IN_INSTR)
RA1  out  AW  regfile read address 1 (combinational from IN_INSTR)
RD0  in  DW  regfile data for RA0, same cycle
RD1  in  DW  regfile data for RA1, same cycle
WB_EN  in  1  write-back valid
WB_ADDR  in  AW  write-back register
WB_DATA  in  DW  write-back data
OUT_VALID  out  1  decoded bundle valid
OUT_READY  in  1  execute consumes bundle
OUT_OPCODE  out  5  opcode
OUT_VALA  out  DW  operand A
OUT_VALB  out  DW  operand B
OUT_IMM  out  DW  extended immediate
OUT_DEST  out  AW  destination register
OUT_WEN  out  1  instruction writes OUT_DEST
OUT_PC  out  PCW  PC of bundle
OUT_ILLEGAL  out  1  opcode 23..31

Behaviour:
- Reset (RSTN low, async): OUT_VALID=0; all OUT_* data=0; held source tags cleared. IN_READY=1 whenever OUT_VALID=0.
- Fields:
  - ra=INSTR[26:22], rb=INSTR[21:17], rc=INSTR[16:12].
  - imm17=INSTR[16:0], imm22=INSTR[21:0], shamt=INSTR[4:0], shmode=INSTR[5].
- Opcode map: ADDI 0, ANDI 1, ORI 2, MOVI 3, ADD 4, SUB 5, NEG 6, NOT 7, AND 8, OR 9, XOR 10, LSR 11, ASR 12, SHL 13, ROR 14, BR 15, BRL 16, J 17, JL 18, LD 19, LDR 20, ST 21, STR 22.
- Operand selection:
  - I-type (ADDI, ANDI, ORI, MOVI, LD, ST):
    - RA0=rb, RA1=ra.
    - IMM = sign-extend imm17 for ADDI/LD/ST; zero-extend imm17 for ANDI/ORI/MOVI.
    - DEST=ra; WEN=1 except ST.
  - R-type (ADD, SUB, NEG, NOT, AND, OR, XOR): RA0=rb, RA1=rc, DEST=ra, WEN=1.
  - Shift (LSR, ASR, SHL, ROR):
    - RA0=rb.
    - shmode=1: VALB from rc (RA1=rc). shmode=0: VALB=zero-extended shamt, with no B source tag.
    - DEST=ra, WEN=1.
  - BR/BRL: RA0=rb (target), RA1=rc (condition); IMM=INSTR[2:0] zero-extended; BRL: DEST=ra, WEN=1.
  - J/JL/LDR/STR:
    - IMM = sign-extend imm22. RA1=ra.
    - JL/LDR: DEST=ra, WEN=1. J/STR: WEN=0.
- Bypass at capture: VALA = (WB_EN && WB_ADDR==RA0) ? WB_DATA : RD0. VALB uses the same rule with RA1/RD1 when B is register-sourced.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - Capture when IN_VALID && IN_READY && !FLUSH; OUT_VALID=1 next cycle.
  - If OUT_READY && !capture: OUT_VALID=0.
  - Zero-bubble throughput: 1 instruction/cycle; latency 1 cycle.
- Stall (OUT_VALID && !OUT_READY):
  - All outputs held stable.
  - Exception: if WB_EN and WB_ADDR equals a held register-sourced A/B tag, that operand is replaced with WB_DATA at the edge. Both may update in the same cycle.
- FLUSH: synchronous; OUT_VALID=0 next cycle; any incoming instruction that cycle is dropped. Priority: FLUSH > capture > drain.
- Reset mid-stall: bundle discarded, no output retained.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: opcodes 23..31 captured with OUT_ILLEGAL=1, OUT_WEN=0, operands 0.
- Undefined: opcodes 23..31 captured as NOP (OUT_WEN=0); OUT_ILLEGAL tied 0.

Test Plan:
1. ADDI r3,r1,-5 (IMM field 0x1FFFB), RD0=10, OUT_READY=1 -> next cycle OUT_VALID=1, VALA=10, IMM=0xFFFFFFFB, DEST=3, WEN=1.
2. ORI with imm17=0x10000 -> IMM=0x00010000. LSR shmode=0 shamt=7 -> VALB=7. LSR shmode=1 with RD1=3 -> VALB=3.
3. ADD r2,r4,r5 with RD0=1 and WB_EN=1, WB_ADDR=4, WB_DATA=99 in the same cycle -> VALA=99.
4. Hold OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0, outputs stable. Then WB writes held A source =0x55 -> VALA becomes 0x55 next cycle. Release -> next instruction captured same cycle, no bubble.
5. FLUSH=1 with OUT_VALID=1 and IN_VALID=1 -> OUT_VALID=0 next cycle, incoming dropped. Assert RSTN=0 mid-stall -> OUT_VALID=0 immediately.
6. Opcode 25 with ILLEGAL_OP_TRAP_EN -> OUT_ILLEGAL=1, WEN=0. Without the macro -> OUT_ILLEGAL=0, WEN=0.
